// File: rtl/pcie_tlp_rr_arb.sv
// Round-robin arbiter: picks the first requester at or after ptr+1 (mod PORTS).
// The pointer only moves on advance_i, which the caller raises when a grant is taken.
module pcie_tlp_rr_arb #(
  parameter int PORTS = 4,
  parameter int PW    = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PORTS-1:0] req_i,
  input  logic             advance_i,
  output logic [PORTS-1:0] grant_o,
  output logic [PW-1:0]    grant_idx_o,
  output logic             grant_valid_o
);

  logic [PW-1:0] ptr_q;

  // Scanning from the farthest position down lets the nearest requester win last.
  always_comb begin
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    for (int k = PORTS; k >= 1; k--) begin
      if (req_i[(int'(ptr_q) + k) % PORTS]) begin
        grant_idx_o   = PW'((int'(ptr_q) + k) % PORTS);
        grant_valid_o = 1'b1;
      end
    end
    if (grant_valid_o) grant_o[grant_idx_o] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= grant_idx_o;
    end
  end

endmodule

// File: rtl/pcie_tlp_mux_rr.sv
// N-to-1 PCIe TLP multiplexer with packet-atomic round-robin grants,
// framing-error drop, and a registered 2-entry skid output stage.
module pcie_tlp_mux_rr #(
  parameter int PORTS          = 4,
  parameter int TLP_DATA_WIDTH = 256,
  parameter int TLP_STRB_WIDTH = TLP_DATA_WIDTH / 32,
  parameter int TLP_HDR_WIDTH  = 128,
  parameter int SEQ_NUM_WIDTH  = 6,
  localparam int PW            = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [PORTS*TLP_DATA_WIDTH-1:0]    in_tlp_data,
  input  logic [PORTS*TLP_STRB_WIDTH-1:0]    in_tlp_strb,
  input  logic [PORTS*TLP_HDR_WIDTH-1:0]     in_tlp_hdr,
  input  logic [PORTS*SEQ_NUM_WIDTH-1:0]     in_tlp_seq,
  input  logic [PORTS*3-1:0]                 in_tlp_bar_id,
  input  logic [PORTS*8-1:0]                 in_tlp_func_num,
  input  logic [PORTS*4-1:0]                 in_tlp_error,
  input  logic [PORTS-1:0]                   in_tlp_valid,
  input  logic [PORTS-1:0]                   in_tlp_sop,
  input  logic [PORTS-1:0]                   in_tlp_eop,
  output logic [PORTS-1:0]                   in_tlp_ready,
  output logic [TLP_DATA_WIDTH-1:0]          out_tlp_data,
  output logic [TLP_STRB_WIDTH-1:0]          out_tlp_strb,
  output logic [TLP_HDR_WIDTH-1:0]           out_tlp_hdr,
  output logic [SEQ_NUM_WIDTH-1:0]           out_tlp_seq,
  output logic [2:0]                         out_tlp_bar_id,
  output logic [7:0]                         out_tlp_func_num,
  output logic [3:0]                         out_tlp_error,
  output logic                               out_tlp_valid,
  output logic                               out_tlp_sop,
  output logic                               out_tlp_eop,
  input  logic                               out_tlp_ready,
  output logic [PW-1:0]                      out_tlp_port,
  input  logic                               enable,
  output logic                               stat_drop
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  typedef struct packed {
    logic [TLP_DATA_WIDTH-1:0] data;
    logic [TLP_STRB_WIDTH-1:0] strb;
    logic [TLP_HDR_WIDTH-1:0]  hdr;
    logic [SEQ_NUM_WIDTH-1:0]  seq;
    logic [2:0]                bar_id;
    logic [7:0]                func_num;
    logic [3:0]                error;
    logic                      sop;
    logic                      eop;
    logic [PW-1:0]             port;
  } beat_t;

  state_t        state_q;
  logic [PW-1:0] grant_idx_q;
  logic          gap_q;
  logic          run_q;
  logic          stat_drop_q;
  logic [1:0]    occ_q;
  beat_t         head_q, skid_q;

  logic [PORTS-1:0] arb_req, arb_grant, ready;
  logic [PW-1:0]    arb_idx, sel, drop_idx;
  logic             arb_valid, has_space, push, pop, drop, advance;
  beat_t            beat_in;

  pcie_tlp_rr_arb #(.PORTS(PORTS), .PW(PW)) u_arb (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (arb_req),
    .advance_i     (advance),
    .grant_o       (arb_grant),
    .grant_idx_o   (arb_idx),
    .grant_valid_o (arb_valid)
  );

  // gap_q forces one grant-free cycle after every EOP; run_q keeps ready low in reset.
  always_comb begin
    has_space = run_q && (occ_q != 2'd2);
    arb_req   = (state_q == IDLE && enable && !gap_q) ? (in_tlp_valid & in_tlp_sop) : '0;
    ready     = '0;
    push      = 1'b0;
    advance   = 1'b0;
    drop      = 1'b0;
    drop_idx  = '0;
    sel       = grant_idx_q;
    if (state_q == IDLE) begin
      sel = arb_idx;
      if (arb_valid && has_space) begin
        ready   = arb_grant;
        push    = 1'b1;
        advance = 1'b1;
      end
      for (int i = PORTS - 1; i >= 0; i--) begin
        if (run_q && in_tlp_valid[i] && !in_tlp_sop[i]) begin
          drop     = 1'b1;
          drop_idx = PW'(i);
        end
      end
      if (drop) ready[drop_idx] = 1'b1;
    end else begin
      if (has_space) ready[grant_idx_q] = 1'b1;
      push = has_space && in_tlp_valid[grant_idx_q];
    end
    pop = (occ_q != 2'd0) && out_tlp_ready;
  end

  always_comb begin
    beat_in.data     = in_tlp_data[int'(sel)*TLP_DATA_WIDTH +: TLP_DATA_WIDTH];
    beat_in.strb     = in_tlp_strb[int'(sel)*TLP_STRB_WIDTH +: TLP_STRB_WIDTH];
    beat_in.hdr      = in_tlp_hdr[int'(sel)*TLP_HDR_WIDTH +: TLP_HDR_WIDTH];
    beat_in.seq      = in_tlp_seq[int'(sel)*SEQ_NUM_WIDTH +: SEQ_NUM_WIDTH];
    beat_in.bar_id   = in_tlp_bar_id[int'(sel)*3 +: 3];
    beat_in.func_num = in_tlp_func_num[int'(sel)*8 +: 8];
    beat_in.error    = in_tlp_error[int'(sel)*4 +: 4];
    beat_in.sop      = in_tlp_sop[sel];
    beat_in.eop      = in_tlp_eop[sel];
    beat_in.port     = sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      gap_q       <= 1'b0;
      run_q       <= 1'b0;
      stat_drop_q <= 1'b0;
      occ_q       <= 2'd0;
      head_q      <= '0;
      skid_q      <= '0;
    end else begin
      run_q       <= 1'b1;
      stat_drop_q <= drop;
      gap_q       <= push && beat_in.eop;
      case (state_q)
        IDLE: if (push) begin
          grant_idx_q <= arb_idx;
          if (!beat_in.eop) state_q <= ACTIVE;
        end
        default: if (push && beat_in.eop) state_q <= IDLE;
      endcase
      // head_q drives the outputs and only changes when empty or popped.
      case (occ_q)
        2'd0: if (push) begin
          head_q <= beat_in;
          occ_q  <= 2'd1;
        end
        2'd1: begin
          if (push && pop) begin
            head_q <= beat_in;
          end else if (push) begin
            skid_q <= beat_in;
            occ_q  <= 2'd2;
          end else if (pop) begin
            occ_q  <= 2'd0;
          end
        end
        default: if (pop) begin
          head_q <= skid_q;
          occ_q  <= 2'd1;
        end
      endcase
    end
  end

  assign in_tlp_ready     = ready;
  assign out_tlp_valid    = (occ_q != 2'd0);
  assign out_tlp_data     = head_q.data;
  assign out_tlp_strb     = head_q.strb;
  assign out_tlp_hdr      = head_q.hdr;
  assign out_tlp_seq      = head_q.seq;
  assign out_tlp_bar_id   = head_q.bar_id;
  assign out_tlp_func_num = head_q.func_num;
  assign out_tlp_error    = head_q.error;
  assign out_tlp_sop      = head_q.sop;
  assign out_tlp_eop      = head_q.eop;
  assign out_tlp_port     = head_q.port;
  assign stat_drop        = stat_drop_q;

endmodule

// File: tb/tb_pcie_tlp_mux_rr.sv
// Directed bench for pcie_tlp_mux_rr: arbitration order, atomicity, backpressure,
// framing drop, enable gating and mid-packet reset against hand-written expectations.
module tb_pcie_tlp_mux_rr;

  localparam int P  = 4;
  localparam int DW = 256;
  localparam int SW = DW / 32;
  localparam int HW = 128;
  localparam int QW = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [P*DW-1:0]   in_tlp_data;
  logic [P*SW-1:0]   in_tlp_strb;
  logic [P*HW-1:0]   in_tlp_hdr;
  logic [P*QW-1:0]   in_tlp_seq;
  logic [P*3-1:0]    in_tlp_bar_id;
  logic [P*8-1:0]    in_tlp_func_num;
  logic [P*4-1:0]    in_tlp_error;
  logic [P-1:0]      in_tlp_valid, in_tlp_sop, in_tlp_eop, in_tlp_ready;
  logic [DW-1:0]     out_tlp_data;
  logic [SW-1:0]     out_tlp_strb;
  logic [HW-1:0]     out_tlp_hdr;
  logic [QW-1:0]     out_tlp_seq;
  logic [2:0]        out_tlp_bar_id;
  logic [7:0]        out_tlp_func_num;
  logic [3:0]        out_tlp_error;
  logic              out_tlp_valid, out_tlp_sop, out_tlp_eop, out_tlp_ready;
  logic [1:0]        out_tlp_port;
  logic              enable;
  logic              stat_drop;

  logic        dv[P], ds[P], de[P];
  logic [15:0] dt[P];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] qOut[$];
  int          qCyc[$];
  logic [31:0] expQ[$];
  bit watchR1 = 0, watchR2 = 0, watchAcc = 0;
  int r1Bad = 0, r2Bad = 0, acc0 = 0;

  always #5 clk = ~clk;

  pcie_tlp_mux_rr dut (
    .clk(clk), .rst_n(rst_n),
    .in_tlp_data(in_tlp_data), .in_tlp_strb(in_tlp_strb), .in_tlp_hdr(in_tlp_hdr),
    .in_tlp_seq(in_tlp_seq), .in_tlp_bar_id(in_tlp_bar_id), .in_tlp_func_num(in_tlp_func_num),
    .in_tlp_error(in_tlp_error), .in_tlp_valid(in_tlp_valid), .in_tlp_sop(in_tlp_sop),
    .in_tlp_eop(in_tlp_eop), .in_tlp_ready(in_tlp_ready),
    .out_tlp_data(out_tlp_data), .out_tlp_strb(out_tlp_strb), .out_tlp_hdr(out_tlp_hdr),
    .out_tlp_seq(out_tlp_seq), .out_tlp_bar_id(out_tlp_bar_id), .out_tlp_func_num(out_tlp_func_num),
    .out_tlp_error(out_tlp_error), .out_tlp_valid(out_tlp_valid), .out_tlp_sop(out_tlp_sop),
    .out_tlp_eop(out_tlp_eop), .out_tlp_ready(out_tlp_ready), .out_tlp_port(out_tlp_port),
    .enable(enable), .stat_drop(stat_drop)
  );

  // Per-port driver arrays are packed into the DUT's flat vectors here.
  always_comb begin
    in_tlp_data = '0; in_tlp_strb = '0; in_tlp_hdr = '0; in_tlp_seq = '0;
    in_tlp_bar_id = '0; in_tlp_func_num = '0; in_tlp_error = '0;
    in_tlp_valid = '0; in_tlp_sop = '0; in_tlp_eop = '0;
    for (int i = 0; i < P; i++) begin
      in_tlp_data[i*DW +: DW]   = {16{dt[i]}};
      in_tlp_strb[i*SW +: SW]   = dt[i][7:0];
      in_tlp_hdr[i*HW +: HW]    = {120'b0, dt[i][7:0] ^ 8'hA5};
      in_tlp_seq[i*QW +: QW]    = dt[i][5:0];
      in_tlp_bar_id[i*3 +: 3]   = 3'(i);
      in_tlp_func_num[i*8 +: 8] = dt[i][11:4];
      in_tlp_error[i*4 +: 4]    = dt[i][3:0];
      in_tlp_valid[i]           = dv[i];
      in_tlp_sop[i]             = ds[i];
      in_tlp_eop[i]             = de[i];
    end
  end

  // Output monitor and side-band watchers, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (rst_n && out_tlp_valid && out_tlp_ready) begin
      qOut.push_back({4'(out_tlp_port), out_tlp_data[15:0], out_tlp_hdr[7:0], 2'b00,
                      out_tlp_sop, out_tlp_eop});
      qCyc.push_back(cyc);
    end
    if (watchR1 && in_tlp_ready[1]) r1Bad++;
    if (watchR2 && in_tlp_ready[2]) r2Bad++;
    if (watchAcc && in_tlp_valid[0] && in_tlp_ready[0]) acc0++;
  end

  function automatic logic [31:0] ent(input int p, input int pkt, input int b,
                                      input bit sop, input bit eop);
    logic [15:0] tag;
    tag = {4'(p), 8'(pkt), 4'(b)};
    return {4'(p), tag, tag[7:0] ^ 8'hA5, 2'b00, sop, eop};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic compareOut(input string tag);
    checkOutput({tag, "_count"}, qOut.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < qOut.size(); i++)
      checkOutput($sformatf("%s_%0d", tag, i), qOut[i], expQ[i]);
  endtask

  // Drives one packet on port p, holding each beat until the DUT accepts it.
  task automatic applyStimulus(input int p, input int n, input int pkt);
    bit acc;
    int budget;
    for (int b = 0; b < n; b++) begin
      dv[p] = 1'b1; ds[p] = (b == 0); de[p] = (b == n - 1);
      dt[p] = {4'(p), 8'(pkt), 4'(b)};
      acc = 1'b0; budget = 0;
      while (!acc && budget < 60) begin
        @(negedge clk); acc = in_tlp_ready[p];
        @(posedge clk); #1; budget++;
      end
      if (!acc) begin
        checkOutput($sformatf("accept_timeout_p%0d", p), 32'd0, 32'd1);
        dv[p] = 1'b0;
        return;
      end
    end
    dv[p] = 1'b0; ds[p] = 1'b0; de[p] = 1'b0;
  endtask

  task automatic startTest();
    repeat (8) @(posedge clk);
    #1;
    qOut.delete(); qCyc.delete(); expQ.delete();
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bad;
    logic [15:0] snap;
    for (int i = 0; i < P; i++) begin dv[i] = 0; ds[i] = 0; de[i] = 0; dt[i] = '0; end
    enable = 1'b1; out_tlp_ready = 1'b1;
    rst_n = 1'b0;
    dv[0] = 1'b1; ds[0] = 1'b1;
    #2;
    checkOutput("rst_out_valid", out_tlp_valid, 0);
    checkOutput("rst_in_ready", in_tlp_ready, 0);
    checkOutput("rst_stat_drop", stat_drop, 0);
    checkOutput("rst_out_port", out_tlp_port, 0);
    dv[0] = 1'b0; ds[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single-beat TLPs from all ports: ptr=0 so port 1 goes first.
    startTest();
    fork
      begin applyStimulus(0, 1, 0); applyStimulus(0, 1, 1); end
      begin applyStimulus(1, 1, 0); applyStimulus(1, 1, 1); end
      begin applyStimulus(2, 1, 0); applyStimulus(2, 1, 1); end
      begin applyStimulus(3, 1, 0); applyStimulus(3, 1, 1); end
    join
    repeat (4) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      expQ.push_back(ent(1, k, 0, 1, 1)); expQ.push_back(ent(2, k, 0, 1, 1));
      expQ.push_back(ent(3, k, 0, 1, 1)); expQ.push_back(ent(0, k, 0, 1, 1));
    end
    compareOut("rr_single");
    bad = 0;
    for (int i = 1; i < qCyc.size(); i++) if (qCyc[i] - qCyc[i-1] != 2) bad++;
    checkOutput("rr_gap", bad, 0);

    // Packet atomicity: port 1 4-beat, port 2 SOP arrives during beat 2.
    startTest();
    fork
      begin applyStimulus(1, 4, 2); watchR2 = 0; end
      begin @(posedge clk); #1; watchR2 = 1; applyStimulus(2, 2, 2); end
    join
    repeat (4) @(posedge clk);
    for (int b = 0; b < 4; b++) expQ.push_back(ent(1, 2, b, b == 0, b == 3));
    expQ.push_back(ent(2, 2, 0, 1, 0)); expQ.push_back(ent(2, 2, 1, 0, 1));
    compareOut("atomic");
    checkOutput("atomic_ready2_low", r2Bad, 0);
    bad = 0;
    for (int i = 1; i < 4 && i < qCyc.size(); i++) if (qCyc[i] - qCyc[i-1] != 1) bad++;
    checkOutput("atomic_contiguous", bad, 0);
    if (qCyc.size() > 4) checkOutput("atomic_boundary_gap", qCyc[4] - qCyc[3], 2);

    // Backpressure: out ready low for 5 cycles after 2 beats have left.
    startTest();
    fork
      applyStimulus(0, 6, 3);
      begin
        bad = 0;
        while (qOut.size() < 2 && bad < 100) begin @(posedge clk); bad++; end
        #1; out_tlp_ready = 1'b0; watchAcc = 1'b1;
        @(negedge clk); snap = out_tlp_data[15:0];
        bad = 0;
        repeat (4) begin
          @(negedge clk);
          if (out_tlp_data[15:0] !== snap || !out_tlp_valid) bad++;
        end
        checkOutput("stall_stable", bad, 0);
        checkOutput("stall_ready_low", in_tlp_ready[0], 0);
        @(posedge clk); #1; out_tlp_ready = 1'b1; watchAcc = 1'b0;
        checkOutput("stall_accepts_le2", (acc0 <= 2), 1);
      end
    join
    repeat (6) @(posedge clk);
    for (int b = 0; b < 6; b++) expQ.push_back(ent(0, 3, b, b == 0, b == 5));
    compareOut("stall");

    // Framing error on port 3, then simultaneous SOPs show the pointer did not move.
    startTest();
    dv[3] = 1'b1; ds[3] = 1'b0; de[3] = 1'b1; dt[3] = {4'd3, 8'd4, 4'd0};
    @(negedge clk);
    checkOutput("drop_ready", in_tlp_ready[3], 1);
    checkOutput("drop_stat_before", stat_drop, 0);
    @(posedge clk); #1; dv[3] = 1'b0; de[3] = 1'b0;
    @(negedge clk); checkOutput("drop_stat_pulse", stat_drop, 1);
    @(negedge clk); checkOutput("drop_stat_clear", stat_drop, 0);
    repeat (3) @(posedge clk);
    checkOutput("drop_no_output", qOut.size(), 0);
    #1;
    fork
      applyStimulus(0, 1, 5);
      applyStimulus(1, 1, 5);
    join
    repeat (4) @(posedge clk);
    expQ.push_back(ent(1, 5, 0, 1, 1)); expQ.push_back(ent(0, 5, 0, 1, 1));
    compareOut("drop_ptr");

    // enable low during port 0's 3-beat packet while port 1 requests.
    startTest();
    fork
      applyStimulus(0, 3, 6);
      begin
        @(posedge clk); #1; enable = 1'b0; watchR1 = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("enable_p0_done", qOut.size(), 3);
        watchR1 = 1'b0; enable = 1'b1;
      end
      begin @(posedge clk); #1; applyStimulus(1, 2, 6); end
    join
    repeat (4) @(posedge clk);
    for (int b = 0; b < 3; b++) expQ.push_back(ent(0, 6, b, b == 0, b == 2));
    expQ.push_back(ent(1, 6, 0, 1, 0)); expQ.push_back(ent(1, 6, 1, 0, 1));
    compareOut("enable");
    checkOutput("enable_ready1_low", r1Bad, 0);

    // Reset on beat 2 of a 4-beat packet from port 2.
    startTest();
    dv[2] = 1'b1; ds[2] = 1'b1; de[2] = 1'b0; dt[2] = {4'd2, 8'd7, 4'd0};
    @(negedge clk); checkOutput("rstmid_ready_b0", in_tlp_ready[2], 1);
    @(posedge clk); #1; ds[2] = 1'b0; dt[2] = {4'd2, 8'd7, 4'd1};
    @(posedge clk); #1; dt[2] = {4'd2, 8'd7, 4'd2};
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstmid_out_valid", out_tlp_valid, 0);
    checkOutput("rstmid_in_ready", in_tlp_ready, 0);
    checkOutput("rstmid_out_data", out_tlp_data[31:0], 0);
    dv[2] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    startTest();
    applyStimulus(0, 2, 8);
    repeat (4) @(posedge clk);
    expQ.push_back(ent(0, 8, 0, 1, 0)); expQ.push_back(ent(0, 8, 1, 0, 1));
    compareOut("rstmid_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
